// File: rtl/lsu_ctrl.sv
// Load/store unit controller: sub-word loads with extension and byte/half stores
// done as read-modify-write on a full-word synchronous memory.
module lsu_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_memop,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, MERGE, WR, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  addr_lo_p0;
  logic [2:0]  memop_p0;
  logic        we_p0;
  logic [15:0] wdata_p0;
  logic        accept, req_err, word_st;

  function automatic logic req_error(input logic [2:0] op, input logic [1:0] a);
    logic illegal, misaligned;
    illegal    = (op == 3'b011) || (op == 3'b100) || (op == 3'b111);
    misaligned = ((op[1:0] == 2'b10) && a[0]) || ((op[1:0] == 2'b00) && (a != 2'b00));
    return illegal || misaligned;
  endfunction

  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                    input logic [2:0] op, input logic [1:0] a);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    b = word[{a, 3'b000} +: 8];
    h = a[1] ? word[DATA_W-1:16] : word[15:0];
    case (op[1:0])
      2'b01:   r = op[2] ? {{(DATA_W-8){1'b0}}, b} : {{(DATA_W-8){b[7]}}, b};
      2'b10:   r = op[2] ? {{(DATA_W-16){1'b0}}, h} : {{(DATA_W-16){h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] word,
                                                    input logic [15:0] wd,
                                                    input logic [2:0] op, input logic [1:0] a);
    logic [DATA_W-1:0] r;
    r = word;
    if (op[1:0] == 2'b01) r[{a, 3'b000} +: 8] = wd[7:0];
    else                  r[{a[1], 4'b0000} +: 16] = wd;
    return r;
  endfunction

  assign accept   = req_valid && req_ready;
  assign req_err  = req_error(req_memop, req_addr[1:0]);
  assign word_st  = req_we && (req_memop == 3'b000);

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign mem_cs    = (state_q == RD) || (state_q == WR);
  assign mem_we    = (state_q == WR);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_err ? RESP : (word_st ? WR : RD);
      RD:      state_d = MERGE;
      MERGE:   state_d = we_p0 ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accept stage: latch request fields; MERGE stage: extend load or merge store lane
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_lo_p0 <= '0;
      memop_p0   <= '0;
      we_p0      <= 1'b0;
      wdata_p0   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else if (accept) begin
      addr_lo_p0 <= req_addr[1:0];
      memop_p0   <= req_memop;
      we_p0      <= req_we;
      wdata_p0   <= req_wdata[15:0];
      mem_addr   <= {req_addr[ADDR_W-1:2], 2'b00};
      rsp_rdata  <= '0;
      rsp_err    <= req_err;
      if (word_st && !req_err) mem_wdata <= req_wdata;
    end else if (state_q == MERGE) begin
      if (we_p0) mem_wdata <= store_merge(mem_rdata, wdata_p0, memop_p0, addr_lo_p0);
      else       rsp_rdata <= load_extend(mem_rdata, memop_p0, addr_lo_p0);
    end
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have a single clock `clk`, input, 1 bit; all state changes on its rising edge.
REQ-002 The block SHALL have reset `rstn`, input, 1 bit, asynchronous, active-low.
REQ-003 The block SHALL have `req_valid`, input, 1 bit: the CPU request is present.
REQ-004 The block SHALL have `req_ready`, output, 1 bit: the block accepts a request this cycle.
REQ-005 The block SHALL have `req_we`, input, 1 bit: 1 = store, 0 = load.
REQ-006 The block SHALL have `req_memop`, input, 3 bits, encoded as:
- 000 word
- 001 byte signed
- 010 half signed
- 101 byte unsigned
- 110 half unsigned
REQ-007 The block SHALL have `req_addr`, input, 16 bits: byte address.
REQ-008 The block SHALL have `req_wdata`, input, 32 bits: store data, right-aligned.
REQ-009 The block SHALL have `rsp_valid`, output, 1 bit: a response is present.
REQ-010 The block SHALL have `rsp_ready`, input, 1 bit: the CPU consumes the response.
REQ-011 The block SHALL have `rsp_rdata`, output, 32 bits: extended load data, 0 for stores and errors.
REQ-012 The block SHALL have `rsp_err`, output, 1 bit: misaligned access or illegal memop.
REQ-013 The block SHALL have `mem_cs`, output, 1 bit: memory chip select.
REQ-014 The block SHALL have `mem_we`, output, 1 bit: memory write enable, full-word write.
REQ-015 The block SHALL have `mem_addr`, output, 16 bits: word-aligned byte address {addr[15:2],2'b00}.
REQ-016 The block SHALL have `mem_wdata`, output, 32 bits: full word to write.
REQ-017 The block SHALL have `mem_rdata`, input, 32 bits: raw word, valid the cycle after a read strobe.

Function
REQ-018 The FSM SHALL have states IDLE, RD, MERGE, WR, RESP.
REQ-019 `req_ready` SHALL be 1 only in IDLE.
REQ-020 A request SHALL be accepted on a clock edge with req_valid=1 and req_ready=1; addr, memop, we and wdata are latched at that edge.
REQ-021 Illegal memop SHALL be any of 011, 100, 111, for loads and stores.
REQ-022 A misaligned access SHALL be:
- memop[1:0]=10 with addr[0]=1, or
- memop[1:0]=00 with addr[1:0]!=00.
REQ-023 An error request SHALL go IDLE->RESP with rsp_err=1 and rsp_rdata=0; mem_cs stays 0 throughout.
REQ-024 A word store SHALL go IDLE->WR->RESP: WR drives mem_cs=1, mem_we=1, mem_wdata=req_wdata.
REQ-025 A load, or a byte/half store, SHALL go IDLE->RD->MERGE: RD drives mem_cs=1, mem_we=0; MERGE samples mem_rdata.
REQ-026 In MERGE, a load SHALL select the lane by addr[1:0]:
- byte: bits [8k+7:8k], k=addr[1:0]
- half: bits [31:16] if addr[1]=1, else [15:0]
REQ-027 The selected load lane SHALL be sign-extended if memop[2]=0 and zero-extended if memop[2]=1, registered into rsp_rdata, then MERGE->RESP.
REQ-028 In MERGE, a sub-word store SHALL replace only the addressed lane of mem_rdata with wdata[7:0] or wdata[15:0], register the merged word, then MERGE->WR->RESP.
REQ-029 A store with memop[2]=1 (101, 110) SHALL be treated as byte or half per memop[1:0].
REQ-030 In any state other than RD and WR, mem_cs and mem_we SHALL be 0.
REQ-031 mem_addr and mem_wdata SHALL be registered and stable through the RD and WR cycles.
REQ-032 In RESP, rsp_valid=1 and rsp_rdata/rsp_err SHALL hold until rsp_ready=1; on that edge the FSM goes to IDLE.
REQ-033 A new request SHALL be accepted no earlier than the cycle after the RESP handshake; there is no back-to-back bypass.
REQ-034 Latency from accept edge to rsp_valid SHALL be: error 1 cycle, word store 2, load 3, sub-word store 4.
REQ-035 req_valid deasserting mid-operation SHALL have no effect; latched fields are used.

Reset
REQ-036 On rstn=0 the FSM SHALL go to IDLE immediately, including mid-operation; an in-flight RMW is abandoned and no WR is issued.
REQ-037 During and after reset, until the first request, outputs SHALL be:
- rsp_valid=0, rsp_err=0, rsp_rdata=0
- mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0
- req_ready=1

Verification
REQ-038 Load byte signed, memop=001, addr=0x0006, memory word 0x12F45678 -> rsp_rdata=0xFFFFFFF4 three cycles after accept; load byte unsigned, memop=101, same address -> rsp_rdata=0x000000F4.
REQ-039 Store half, memop=010, addr=0x0012, wdata=0xAAAABEEF, memory 0x11223344 -> read at 0x0010, then write 0xBEEF3344 at 0x0010; rsp_valid four cycles after accept, rsp_rdata=0.
REQ-040 Word load, memop=000, addr=0x0005 -> rsp_err=1 one cycle after accept; mem_cs never asserted; memop=011 gives the same result.
REQ-041 Hold rsp_ready=0 for 5 cycles during a load response -> rsp_valid and rsp_rdata stable, req_ready=0; a new req_valid is not accepted until one cycle after rsp_ready=1.
REQ-042 Assert rstn=0 during the MERGE cycle of a byte store -> mem_we never asserts for that request; req_ready=1 and all outputs at reset values while rstn=0.
REQ-043 Word store, wdata=0xDEADBEEF, addr=0x0100, then load word at 0x0100 -> read returns 0xDEADBEEF; store response two cycles after accept.
